// File: rtl/mux_pkg.sv
// ============================================================================
//  Module   : mux_pkg
//  Purpose  : Shared types and helpers for the N-to-1 select and skid stage.
//             Provides the stage state enum, an entry-struct declaration
//             macro, and the select clamping function.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// Declares a packed entry struct {data, idx, err} sized for one instance.
// The struct lives in the instantiating module because its widths depend
// on that module's parameters.
`define MUX_ENTRY_T(NAME, DW, SW) \
    typedef struct packed { \
        logic [(DW)-1:0] data; \
        logic [(SW)-1:0] idx;  \
        logic            err;  \
    } NAME

package mux_pkg;

    // Occupancy of the two-entry skid stage
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } st_t;

    // Result of clamping a select value against the input count
    typedef struct packed {
        logic        err;
        logic [31:0] idx;
    } sel_res_t;

    // In-range selects pass through; anything else maps to the last input
    // and is flagged so downstream can see the operand was not the one asked for.
    function automatic sel_res_t clamp_sel(input logic [31:0] sel, input logic [31:0] n);
        sel_res_t r;
        if (sel < n) begin
            r.idx = sel;
            r.err = 1'b0;
        end else begin
            r.idx = n - 32'd1;
            r.err = 1'b1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux_n_to_1.sv
// ============================================================================
//  Module   : mux_n_to_1
//  Purpose  : Combinational N-to-1 word select with out-of-range clamping.
//             Returns the selected word, the effective index and an error bit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_n_to_1
    import mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   data,
    output logic [SEL_W-1:0]   idx,
    output logic               err
);

    sel_res_t res;

    // Clamp the select, then pick the word at the effective index
    always_comb begin
        res  = clamp_sel(32'(sel), 32'(N));
        idx  = res.idx[SEL_W-1:0];
        err  = res.err;
        data = in_data[res.idx*WIDTH +: WIDTH];
    end

endmodule

`default_nettype wire

// File: rtl/mux_skid_n.sv
// ============================================================================
//  Module   : mux_skid_n
//  Purpose  : N-to-1 word select followed by a two-entry registered skid
//             stage with valid/ready on both sides, flush and select-range
//             error reporting. in_ready depends on registered state only.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_skid_n
    import mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]   sel,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel,
    output logic               out_sel_err,
    output logic               out_valid,
    input  logic               out_ready
);

    `MUX_ENTRY_T(entry_t, WIDTH, SEL_W);

    st_t    st;
    st_t    st_nxt;
    entry_t main_q;
    entry_t skid_q;
    entry_t in_entry;
    logic   acc;
    logic   take;
    logic   load_main;
    logic   load_skid;
    logic   main_from_skid;

    // Select happens ahead of the entries so each entry stores a finished word
    mux_n_to_1 #(
        .WIDTH (WIDTH),
        .N     (N),
        .SEL_W (SEL_W)
    ) u_sel (
        .in_data (in_data),
        .sel     (sel),
        .data    (in_entry.data),
        .idx     (in_entry.idx),
        .err     (in_entry.err)
    );

    assign in_ready    = (st != TWO);
    assign out_valid   = (st != EMPTY);
    assign acc         = in_valid & in_ready;
    assign take        = out_valid & out_ready;
    assign out_data    = main_q.data;
    assign out_sel     = main_q.idx;
    assign out_sel_err = main_q.err;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            st <= EMPTY;
        end else begin
            st <= st_nxt;
        end
    end

    // Next state and entry load enables; flush overrides every transition
    always_comb begin
        st_nxt         = st;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            st_nxt = EMPTY;
        end else begin
            case (st)
                EMPTY: begin
                    if (acc) begin
                        load_main = 1'b1;
                        st_nxt    = ONE;
                    end
                end
                ONE: begin
                    if (acc && take) begin
                        load_main = 1'b1;
                    end else if (acc) begin
                        load_skid = 1'b1;
                        st_nxt    = TWO;
                    end else if (take) begin
                        st_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (take) begin
                        main_from_skid = 1'b1;
                        st_nxt         = ONE;
                    end
                end
                default: st_nxt = EMPTY;
            endcase
        end
    end

    // Entry storage; main only changes on a load, keeping the head stable while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main) begin
                main_q <= in_entry;
            end else if (main_from_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_entry;
            end
        end
    end

endmodule

`default_nettype wire
